// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/OR/XOR, iterative unsigned MUL/DIV.
// Results and NZCV flags are held until the next done pulse or reset.
module alu_mc #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   ALUControl,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] ALUResult,
    output logic [N-1:0] ALUResultHi,
    output logic [3:0]   ALUFlags
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one MUL/DIV iteration per cycle, counter counts down to 0
    // FIN   | done pulse; result and flags just updated

    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_mul_q, is_mul_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   res_hi_q, res_hi_d;
    logic [3:0]     flags_q, flags_d;

    logic [N:0]     add_full, sub_full;
    logic [N-1:0]   sc_res;
    logic           sc_c, sc_v;
    logic [3:0]     sc_flags;
    logic           is_muldiv;

    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic           div_ge;
    logic [N-1:0]   div_trial;
    logic [N-1:0]   it_hi, it_lo;
    logic [3:0]     it_flags;

    assign is_muldiv = (ALUControl == OP_MUL) || (ALUControl == OP_DIV);

    always_comb begin
        add_full = {1'b0, a} + {1'b0, b};
        sub_full = {1'b0, a} - {1'b0, b};
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                sc_res = add_full[N-1:0];
                sc_c   = add_full[N];
                sc_v   = (a[N-1] == b[N-1]) && (sc_res[N-1] != a[N-1]);
            end
            OP_SUB: begin
                sc_res = sub_full[N-1:0];
                sc_c   = ~sub_full[N];
                sc_v   = (a[N-1] ^ b[N-1]) & (a[N-1] ^ sc_res[N-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            default: sc_res = '0;
        endcase
        sc_flags = {sc_res[N-1], (sc_res == '0), sc_c, sc_v};
    end

    // Shift-add multiply keeps {hi, lo} as partial product / remaining multiplier;
    // restoring divide keeps hi as remainder and shifts quotient bits into lo.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[N-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_trial = div_shift[N-1:0] - b_q;
        if (is_mul_q) begin
            it_hi    = mul_sum[N:1];
            it_lo    = {mul_sum[0], lo_q[N-1:1]};
            it_flags = {it_lo[N-1], ({it_hi, it_lo} == '0), (it_hi != '0), (it_hi != '0)};
        end else begin
            it_hi    = div_ge ? div_trial : div_shift[N-1:0];
            it_lo    = {lo_q[N-2:0], div_ge};
            it_flags = {it_lo[N-1], (it_lo == '0), 1'b0, (b_q == '0)};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE, FIN: begin
                if (state_q == FIN)
                    state_d = IDLE;
                // A single-cycle op arriving in FIN waits for IDLE so done stays a one-cycle pulse.
                if (start && ((state_q == IDLE) || is_muldiv)) begin
                    if (is_muldiv) begin
                        is_mul_d = (ALUControl == OP_MUL);
                        b_d      = b;
                        hi_d     = '0;
                        lo_d     = a;
                        cnt_d    = CW'(N);
                        state_d  = RUN;
                    end else begin
                        res_d    = sc_res;
                        res_hi_d = '0;
                        flags_d  = sc_flags;
                        state_d  = FIN;
                    end
                end
            end
            RUN: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d    = it_lo;
                    res_hi_d = it_hi;
                    flags_d  = it_flags;
                    state_d  = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == FIN);
    assign ALUResult   = res_q;
    assign ALUResultHi = res_hi_q;
    assign ALUFlags    = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed vectors push expected results, a monitor
// pops and compares on every done pulse.
module tb_alu_mc;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   ALUControl = 3'b000;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy, done;
    logic [N-1:0] ALUResult, ALUResultHi;
    logic [3:0]   ALUFlags;

    typedef struct {
        logic [N-1:0] res;
        logic [N-1:0] hi;
        logic [3:0]   flags;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;

    alu_mc #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUControl(ALUControl),
        .a(a), .b(b), .busy(busy), .done(done),
        .ALUResult(ALUResult), .ALUResultHi(ALUResultHi), .ALUFlags(ALUFlags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_lo", int'(ALUResult), int'(e.res));
                check("result_hi", int'(ALUResultHi), int'(e.hi));
                check("flags", int'(ALUFlags), int'(e.flags));
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [N-1:0] va,
                          input logic [N-1:0] vb, input logic [N-1:0] er, input logic [N-1:0] eh,
                          input logic [3:0] ef, input int lat);
        int cyc = 0;
        int busy_cyc = 0;
        int seen = 0;
        sb.push_back('{er, eh, ef});
        @(negedge clk);
        ALUControl = op; a = va; b = vb; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_latency"}, cyc, lat);
        check({name, "_busy_cycles"}, busy_cyc, lat - 1);
        @(negedge clk);
        check({name, "_done_pulse_width"}, int'(done), 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_lo"}, int'(ALUResult), 0);
        check({name, "_hi"}, int'(ALUResultHi), 0);
        check({name, "_flags"}, int'(ALUFlags), 0);
    endtask

    initial begin
        int base;

        // rst and start together: rst wins
        ALUControl = 3'b000; a = 8'h01; b = 8'h01; start = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_start_dropped", done_count, 0);

        run_op("add_ovf",  3'b000, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1001, 1);
        run_op("sub_eq",   3'b001, 8'h05, 8'h05, 8'h00, 8'h00, 4'b0110, 1);
        run_op("sub_neg",  3'b001, 8'h03, 8'h05, 8'hFE, 8'h00, 4'b1000, 1);
        run_op("mul_100",  3'b101, 8'h10, 8'h10, 8'h00, 8'h01, 4'b0011, N + 1);
        run_op("mul_ff",   3'b101, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0011, N + 1);
        run_op("and",      3'b010, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1);
        run_op("or",       3'b011, 8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b1000, 1);
        run_op("xor",      3'b100, 8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0100, 1);
        run_op("add_c",    3'b000, 8'hFF, 8'h02, 8'h01, 8'h00, 4'b0010, 1);
        run_op("rsvd",     3'b111, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0100, 1);
        run_op("div_100",  3'b110, 8'd100, 8'd7, 8'd14, 8'd2, 4'b0000, N + 1);
        run_op("div_zero", 3'b110, 8'h2A, 8'h00, 8'hFF, 8'h2A, 4'b1001, N + 1);
        run_op("mul_zero", 3'b101, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0100, N + 1);

        // start while busy is ignored; operand changes do not disturb the DIV
        sb.push_back('{8'd22, 8'd2, 4'b0000});
        base = done_count;
        @(negedge clk);
        ALUControl = 3'b110; a = 8'd200; b = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        ALUControl = 3'b000; a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h55; b = 8'h33;
        for (int i = 0; i < 40 && done_count == base; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("busy_ignore_done_count", done_count - base, 1);

        // reset on the 4th busy cycle of a MUL aborts it with no done
        base = done_count;
        @(negedge clk);
        ALUControl = 3'b101; a = 8'h10; b = 8'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("abort");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_count - base, 0);
        run_op("add_after_abort", 3'b000, 8'h01, 8'h02, 8'h03, 8'h00, 4'b0000, 1);

        // start held high: one single-cycle result every two cycles
        sb.push_back('{8'h30, 8'h00, 4'b0000});
        sb.push_back('{8'h30, 8'h00, 4'b0000});
        base = done_count;
        @(negedge clk);
        ALUControl = 3'b000; a = 8'h10; b = 8'h20; start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("back_to_back_dones", done_count - base, 2);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
